// File: rtl/mem_read_port.sv
// -----------------------------------------------------------------------------
// mem_read_port
//
// Read side of the MAR/MDR memory interface. A start pulse in IDLE latches the
// word address, a handshaked read is issued, and the block waits a bounded
// number of cycles for the memory acknowledge. The acknowledged word is held
// in data_out, which feeds MDR.
//
// Ports:
//   clk       system clock, rising edge
//   clr       asynchronous active-high reset
//   start     read request pulse, only looked at in IDLE
//   addr      word address, captured with an accepted start
//   mem_addr  address presented to memory, held until the next accepted start
//   mem_rd    memory read strobe (REQ and WAIT)
//   mem_ack   memory acknowledge, data valid in the same cycle
//   mem_data  memory read data
//   busy      high while a read is in flight (REQ and WAIT)
//   done      one-cycle pulse after data_out has been updated
//   err       one-cycle pulse when the acknowledge never arrived
//   data_out  last successfully read word
// -----------------------------------------------------------------------------
module mem_read_port #(
    parameter int AW      = 9,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [AW-1:0] addr,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] data_out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Counter value on the last WAIT edge that may still see an acknowledge.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    cnt;
    logic [7:0]    cnt_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic [DW-1:0] data_out_nxt;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        mem_addr_nxt = mem_addr;
        data_out_nxt = data_out;
        case (state)
            S_IDLE: begin
                if (start) begin
                    mem_addr_nxt = addr;
                    state_nxt    = S_REQ;
                end
            end
            S_REQ: begin
                cnt_nxt   = 8'd0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Acknowledge wins over timeout on the same edge.
                if (mem_ack) begin
                    data_out_nxt = mem_data;
                    state_nxt    = S_DONE;
                end else if (cnt == LAST_WAIT) begin
                    state_nxt = S_ERR;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe without any combinational decode on the ports.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            mem_addr <= '0;
            data_out <= '0;
            mem_rd   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            mem_addr <= mem_addr_nxt;
            data_out <= data_out_nxt;
            mem_rd   <= (state_nxt == S_REQ) || (state_nxt == S_WAIT);
            busy     <= (state_nxt == S_REQ) || (state_nxt == S_WAIT);
            done     <= (state_nxt == S_DONE);
            err      <= (state_nxt == S_ERR);
        end
    end

endmodule

// File: tb/tb_mem_read_port.sv
module tb_mem_read_port;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk;
    logic          clr;
    logic          start;
    logic [AW-1:0] addr;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_ack;
    logic [DW-1:0] mem_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] data_out;

    int checks;
    int failures;

    mem_read_port #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .addr     (addr),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic [AW-1:0] addr;
        logic          ack;
        logic [DW-1:0] mdata;
        logic [AW-1:0] e_addr;
        logic          e_rd;
        logic          e_busy;
        logic          e_done;
        logic          e_err;
        logic [DW-1:0] e_dout;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic [AW-1:0] a, input logic k,
                       input logic [DW-1:0] md, input logic [AW-1:0] ea,
                       input logic erd, input logic eb, input logic ed,
                       input logic ee, input logic [DW-1:0] eo);
        vec_t v;
        v.start = s;  v.addr = a;    v.ack = k;   v.mdata = md;
        v.e_addr = ea; v.e_rd = erd; v.e_busy = eb; v.e_done = ed;
        v.e_err = ee; v.e_dout = eo;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
    task automatic cycle(input logic s, input logic [AW-1:0] a, input logic k,
                         input logic [DW-1:0] md);
        @(negedge clk);
        start = s; addr = a; mem_ack = k; mem_data = md;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [AW-1:0] ea, input logic erd,
                           input logic eb, input logic ed, input logic ee,
                           input logic [DW-1:0] eo);
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(ea));
        chk({tag, ".mem_rd"},   32'(mem_rd),   32'(erd));
        chk({tag, ".busy"},     32'(busy),     32'(eb));
        chk({tag, ".done"},     32'(done),     32'(ed));
        chk({tag, ".err"},      32'(err),      32'(ee));
        chk({tag, ".data_out"}, data_out,      eo);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clr      = 1'b1;
        start    = 1'b0;
        addr     = '0;
        mem_ack  = 1'b0;
        mem_data = '0;

        // Vector table: inputs before an edge, outputs expected after it.
        // Immediate acknowledge.
        add(1, 9'h05A, 0, 32'h0,        9'h05A, 1, 1, 0, 0, 32'h0);        // REQ
        add(0, 9'h000, 0, 32'h0,        9'h05A, 1, 1, 0, 0, 32'h0);        // WAIT
        add(0, 9'h000, 1, 32'hDEADBEEF, 9'h05A, 0, 0, 1, 0, 32'hDEADBEEF); // DONE
        add(0, 9'h000, 0, 32'h0,        9'h05A, 0, 0, 0, 0, 32'hDEADBEEF); // IDLE
        // Delayed acknowledge on the 8th WAIT edge, with a stray start in WAIT.
        add(1, 9'h123, 0, 32'h0,        9'h123, 1, 1, 0, 0, 32'hDEADBEEF); // REQ
        add(0, 9'h000, 0, 32'h0,        9'h123, 1, 1, 0, 0, 32'hDEADBEEF); // WAIT 1
        add(0, 9'h000, 0, 32'h0,        9'h123, 1, 1, 0, 0, 32'hDEADBEEF); // WAIT 2
        add(0, 9'h000, 0, 32'h0,        9'h123, 1, 1, 0, 0, 32'hDEADBEEF); // WAIT 3
        add(1, 9'h1FF, 0, 32'h0,        9'h123, 1, 1, 0, 0, 32'hDEADBEEF); // WAIT 4
        add(0, 9'h000, 0, 32'h0,        9'h123, 1, 1, 0, 0, 32'hDEADBEEF); // WAIT 5
        add(0, 9'h000, 0, 32'h0,        9'h123, 1, 1, 0, 0, 32'hDEADBEEF); // WAIT 6
        add(0, 9'h000, 0, 32'h0,        9'h123, 1, 1, 0, 0, 32'hDEADBEEF); // WAIT 7
        add(0, 9'h000, 0, 32'h0,        9'h123, 1, 1, 0, 0, 32'hDEADBEEF); // WAIT 8
        add(0, 9'h000, 1, 32'h12345678, 9'h123, 0, 0, 1, 0, 32'h12345678); // DONE
        add(0, 9'h000, 0, 32'h0,        9'h123, 0, 0, 0, 0, 32'h12345678); // IDLE
        // Acknowledge while idle is ignored.
        add(0, 9'h000, 1, 32'hFFFFFFFF, 9'h123, 0, 0, 0, 0, 32'h12345678);
        add(0, 9'h000, 1, 32'h0BADF00D, 9'h123, 0, 0, 0, 0, 32'h12345678);
        add(0, 9'h000, 0, 32'h0,        9'h123, 0, 0, 0, 0, 32'h12345678);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 9'h000, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        clr = 1'b0;

        foreach (vecs[i]) begin
            cycle(vecs[i].start, vecs[i].addr, vecs[i].ack, vecs[i].mdata);
            chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_rd,
                    vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err, vecs[i].e_dout);
        end

        // Timeout: err exactly 16 edges after entering REQ.
        cycle(1, 9'h0AA, 0, 32'h0);
        chk_all("to.req", 9'h0AA, 1, 1, 0, 0, 32'h12345678);
        for (int i = 1; i <= 15; i++) begin
            cycle(0, 9'h000, 0, 32'h0);
            chk($sformatf("to.wait%0d.busy", i), 32'(busy), 32'd1);
            chk($sformatf("to.wait%0d.err", i),  32'(err),  32'd0);
        end
        cycle(0, 9'h000, 0, 32'h0);
        chk_all("to.err", 9'h0AA, 0, 0, 0, 1, 32'h12345678);
        cycle(0, 9'h000, 0, 32'h0);
        chk_all("to.idle", 9'h0AA, 0, 0, 0, 0, 32'h12345678);

        // Acknowledge on the last permitted WAIT edge beats the timeout.
        cycle(1, 9'h0F0, 0, 32'h0);
        for (int i = 1; i <= 15; i++) cycle(0, 9'h000, 0, 32'h0);
        chk("last.pre.busy", 32'(busy), 32'd1);
        cycle(0, 9'h000, 1, 32'hCAFEF00D);
        chk_all("last.done", 9'h0F0, 0, 0, 1, 0, 32'hCAFEF00D);
        cycle(0, 9'h000, 0, 32'h0);
        chk_all("last.idle", 9'h0F0, 0, 0, 0, 0, 32'hCAFEF00D);

        // start held high: REQ, WAIT, DONE, IDLE repeating.
        for (int i = 0; i < 8; i++) begin
            cycle(1, 9'h011, 1, 32'hA5A5A5A5);
            chk($sformatf("b2b%0d.busy", i), 32'(busy), 32'((i % 4) < 2));
            chk($sformatf("b2b%0d.done", i), 32'(done), 32'((i % 4) == 2));
        end
        cycle(0, 9'h000, 0, 32'h0);
        chk_all("b2b.end", 9'h011, 0, 0, 0, 0, 32'hA5A5A5A5);

        // Asynchronous clear in the middle of WAIT.
        cycle(1, 9'h155, 0, 32'h0);
        cycle(0, 9'h000, 0, 32'h0);
        cycle(0, 9'h000, 0, 32'h0);
        chk("abort.pre.mem_rd", 32'(mem_rd), 32'd1);
        #1;
        clr = 1'b1;
        #1;
        chk_all("abort.clr", 9'h000, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        clr = 1'b0;
        cycle(0, 9'h000, 1, 32'h77777777);
        chk_all("abort.after", 9'h000, 0, 0, 0, 0, 32'h0);
        cycle(0, 9'h000, 0, 32'h0);
        chk_all("abort.idle", 9'h000, 0, 0, 0, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
